ps2_scancode_decoder: RTL and testbench
=======================================

# ps2_scancode_decoder

Consumes the byte stream produced by the PS/2 keyboard receiver: `decoded_key` plus its `read_key` strobe, in scancode set 2. Resolves E0/F0 prefix sequences and tracks modifier state. Translates make codes into ASCII or extended key words and queues them in a small show-ahead FIFO. The CPU I/O bus pops the FIFO with a single-cycle acknowledge.

## Interface
- `FIFO_DEPTH`, 8: queue entries; must be a power of 2 and at least 2.
- `clk` in 1: system clock, 50 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `decoded_key` in 8: scancode byte from the receiver; stable while `read_key` is high.
- `read_key` in 1: receiver strobe; high for about one PS/2 bit period per valid byte; asynchronous to `clk`.
- `key_ack` in 1: pop request; acts only when `key_valid` is 1.
- `key_valid` out 1: FIFO non-empty.
- `key_data` out 16: head entry.
  - [7:0] code
  - [8] extended
  - [9] shift
  - [10] ctrl
  - [15:11] 0
- `key_overflow` out 1: sticky flag; an entry was dropped.
- `caps_lock` out 1: current caps-lock toggle state.

## Operation
- **Input sync:** `read_key` passes through 2 flops. A rising edge on the synchronized value forms a 1-cycle `byte_stb`, and `decoded_key` is captured on that cycle. Sync flops reset to 1, so a `read_key` already high at reset release produces no event.
- **Prefix FSM** states: IDLE, EXT, BRK, EXT_BRK. All transitions happen on `byte_stb` only.
  - IDLE:
    - E0 -> EXT
    - F0 -> BRK
    - any other byte -> process as make (ext=0), stay IDLE
  - EXT:
    - F0 -> EXT_BRK
    - E0 -> EXT
    - any other byte -> process as make (ext=1) -> IDLE
  - BRK: byte -> process as break (ext=0) -> IDLE.
  - EXT_BRK: byte -> process as break (ext=1) -> IDLE.
- **Modifiers:**
  - shift = lshift (12) | rshift (59).
  - ctrl = lctrl (14) | rctrl (E0 14).
  - Each is set on make and cleared on break.
- **Caps lock (58):** toggles on make only when `caps_held`=0, then sets `caps_held`; break clears `caps_held`, so typematic repeats do not re-toggle.
- **Keymap:** for non-modifier makes, `ps2_keymap` returns the code.
  - Letters: 1C 'a'=61 / 'A'=41; case = shift XOR caps.
  - Digits: 16 '1'=31 / '!'=21.
  - Controls: 5A=0D, 66=08, 29=20, 76=1B, 0D=09.
  - Extended arrows: E0 75=80, E0 72=81, E0 6B=82, E0 74=83.
  - Ctrl with a letter yields `code & 1F`.
  - Code 00 (unmapped) is not pushed.
- Break codes push nothing.
- **Push word:** `{5'b0, ctrl, shift, ext, code}`, with modifier values taken before this byte's update.
- **FIFO:**
  - Push on a full FIFO without a same-cycle pop: entry dropped, `key_overflow` set.
  - Push and pop in the same cycle are both honoured, including when full.
  - `key_overflow` clears on the next accepted pop.
  - `key_ack` while empty is ignored.

## Timing
- Reset values: FSM = IDLE; shift, ctrl, `caps_held` = 0; `key_valid` = 0; `key_data` = 0; `key_overflow` = 0; `caps_lock` = 0.
- **Latency:** `read_key` first sampled high at edge N -> `byte_stb` during cycle N+2 -> push at edge N+3 -> `key_valid`=1 from edge N+3 (FIFO previously empty).
- **Pop:** with `key_ack` high at edge M, the next entry (or `key_valid`=0) appears from edge M.
- **Throughput:**
  - One byte per `read_key` pulse.
  - PS/2 bytes arrive at least about 1 ms apart, so no input back-pressure exists.
  - The pipeline needs at most 1 byte in flight.
- **Reset mid-sequence:** an asynchronous reset discards a pending E0/F0 prefix, modifier state and all FIFO contents. The next byte is treated from IDLE.

## Structure
- Package `ps2_pkg`:
  - Prefix constants `SC_EXT`=E0, `SC_BRK`=F0.
  - Modifier codes.
  - Arrow code constants 80..83.
  - FSM state enum.
  - Key word field offsets.
- Sub-module `ps2_keymap`: combinational scancode+ext+shift+caps+ctrl -> 8-bit code ROM.
- FIFO: inline pointer-based, with one extra pointer bit for full/empty.

## Test plan
- Reset, then bytes 1C, F0 1C -> one entry 0061; break pushes nothing; `key_valid` rises exactly 3 edges after the first `read_key` sample.
- Bytes 12, 1C, F0 12, 1C -> entries 0241 then 0061; bytes 58, 58, F0 58, 1C -> `caps_lock`=1 (single toggle), entry 0041.
- Bytes E0 75, E0 F0 75, 14, 1C -> entries 0180 and 0401; E0 14 sets ctrl, E0 F0 14 clears it.
- 9 pushes with no ack (FIFO_DEPTH=8) -> 8 retained, `key_overflow`=1; one ack pops first entry and clears flag; `key_ack` on empty FIFO -> no change.
- FIFO full with simultaneous push and `key_ack` -> count stays 8, no overflow; assert `reset_n` after E0 only, then send 1C -> entry 0061 (ext=0).
- `read_key` held high across `reset_n` release -> no entry pushed.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ps2_pkg                                                    |
// | Brief   : Scancode set 2 constants, prefix FSM states, key word map  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package ps2_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   localparam logic [7:0] KC_UP     = 8'h80;
   localparam logic [7:0] KC_DOWN   = 8'h81;
   localparam logic [7:0] KC_LEFT   = 8'h82;
   localparam logic [7:0] KC_RIGHT  = 8'h83;

   localparam int KW_CODE_LSB = 0;
   localparam int KW_EXT      = 8;
   localparam int KW_SHIFT    = 9;
   localparam int KW_CTRL     = 10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } pfx_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_keymap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ps2_keymap                                                 |
// | Brief   : Combinational set-2 make code to ASCII / extended code ROM |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
import ps2_pkg::*;

module ps2_keymap (
   input  logic [7:0] i_scancode,
   input  logic       i_ext,
   input  logic       i_shift,
   input  logic       i_caps,
   input  logic       i_ctrl,
   output logic [7:0] o_code
);

   logic [7:0] w_letter;
   logic [7:0] w_digit;
   logic [7:0] w_digit_sh;

   always_comb begin
      w_letter = 8'h00;
      case (i_scancode)
         8'h1C: w_letter = 8'h61;  8'h32: w_letter = 8'h62;  8'h21: w_letter = 8'h63;
         8'h23: w_letter = 8'h64;  8'h24: w_letter = 8'h65;  8'h2B: w_letter = 8'h66;
         8'h34: w_letter = 8'h67;  8'h33: w_letter = 8'h68;  8'h43: w_letter = 8'h69;
         8'h3B: w_letter = 8'h6A;  8'h42: w_letter = 8'h6B;  8'h4B: w_letter = 8'h6C;
         8'h3A: w_letter = 8'h6D;  8'h31: w_letter = 8'h6E;  8'h44: w_letter = 8'h6F;
         8'h4D: w_letter = 8'h70;  8'h15: w_letter = 8'h71;  8'h2D: w_letter = 8'h72;
         8'h1B: w_letter = 8'h73;  8'h2C: w_letter = 8'h74;  8'h3C: w_letter = 8'h75;
         8'h2A: w_letter = 8'h76;  8'h1D: w_letter = 8'h77;  8'h22: w_letter = 8'h78;
         8'h35: w_letter = 8'h79;  8'h1A: w_letter = 8'h7A;
         default: w_letter = 8'h00;
      endcase
   end

   always_comb begin
      w_digit    = 8'h00;
      w_digit_sh = 8'h00;
      case (i_scancode)
         8'h16: begin w_digit = 8'h31; w_digit_sh = 8'h21; end
         8'h1E: begin w_digit = 8'h32; w_digit_sh = 8'h40; end
         8'h26: begin w_digit = 8'h33; w_digit_sh = 8'h23; end
         8'h25: begin w_digit = 8'h34; w_digit_sh = 8'h24; end
         8'h2E: begin w_digit = 8'h35; w_digit_sh = 8'h25; end
         8'h36: begin w_digit = 8'h36; w_digit_sh = 8'h5E; end
         8'h3D: begin w_digit = 8'h37; w_digit_sh = 8'h26; end
         8'h3E: begin w_digit = 8'h38; w_digit_sh = 8'h2A; end
         8'h46: begin w_digit = 8'h39; w_digit_sh = 8'h28; end
         8'h45: begin w_digit = 8'h30; w_digit_sh = 8'h29; end
         default: begin w_digit = 8'h00; w_digit_sh = 8'h00; end
      endcase
   end

   // A zero result means "unmapped" and is never queued by the caller
   always_comb begin
      o_code = 8'h00;
      if (i_ext) begin
         case (i_scancode)
            8'h75:   o_code = KC_UP;
            8'h72:   o_code = KC_DOWN;
            8'h6B:   o_code = KC_LEFT;
            8'h74:   o_code = KC_RIGHT;
            default: o_code = 8'h00;
         endcase
      end else if (w_letter != 8'h00) begin
         o_code = (i_shift ^ i_caps) ? (w_letter - 8'h20) : w_letter;
         if (i_ctrl) o_code = o_code & 8'h1F;
      end else if (w_digit != 8'h00) begin
         o_code = i_shift ? w_digit_sh : w_digit;
      end else begin
         case (i_scancode)
            8'h5A:   o_code = 8'h0D;
            8'h66:   o_code = 8'h08;
            8'h29:   o_code = 8'h20;
            8'h76:   o_code = 8'h1B;
            8'h0D:   o_code = 8'h09;
            default: o_code = 8'h00;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ps2_scancode_decoder                                       |
// | Brief   : PS/2 set-2 byte stream to key words, with show-ahead FIFO  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
import ps2_pkg::*;

module ps2_scancode_decoder #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  decoded_key,
   input  logic        read_key,
   input  logic        key_ack,
   output logic        key_valid,
   output logic [15:0] key_data,
   output logic        key_overflow,
   output logic        caps_lock
);

   localparam int AW = $clog2(FIFO_DEPTH);

   if ((FIFO_DEPTH < 2) || ((1 << AW) != FIFO_DEPTH)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
   end

   logic       r_sync1, r_sync2, r_sync3, r_byte_stb;
   logic [7:0] r_byte;

   // Sync flops idle high so a strobe already active at reset release is ignored
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_sync3    <= 1'b1;
         r_byte_stb <= 1'b0;
         r_byte     <= 8'h00;
      end else begin
         r_sync1    <= read_key;
         r_sync2    <= r_sync1;
         r_sync3    <= r_sync2;
         r_byte_stb <= r_sync2 & ~r_sync3;
         if (r_sync2 & ~r_sync3) r_byte <= decoded_key;
      end
   end

   pfx_state_t r_state, w_state_nxt;
   logic       w_make, w_break, w_ext;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_make      = 1'b0;
      w_break     = 1'b0;
      w_ext       = 1'b0;
      if (r_byte_stb) begin
         case (r_state)
            ST_IDLE: begin
               if (r_byte == SC_EXT)      w_state_nxt = ST_EXT;
               else if (r_byte == SC_BRK) w_state_nxt = ST_BRK;
               else                       w_make      = 1'b1;
            end
            ST_EXT: begin
               if (r_byte == SC_BRK)      w_state_nxt = ST_EXT_BRK;
               else if (r_byte == SC_EXT) w_state_nxt = ST_EXT;
               else begin
                  w_make      = 1'b1;
                  w_ext       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_BRK: begin
               w_break     = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            ST_EXT_BRK: begin
               w_break     = 1'b1;
               w_ext       = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   logic r_lshift, r_rshift, r_lctrl, r_rctrl, r_caps_held, r_caps_lock;
   logic w_shift, w_ctrl;

   assign w_shift = r_lshift | r_rshift;
   assign w_ctrl  = r_lctrl | r_rctrl;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lshift    <= 1'b0;
         r_rshift    <= 1'b0;
         r_lctrl     <= 1'b0;
         r_rctrl     <= 1'b0;
         r_caps_held <= 1'b0;
         r_caps_lock <= 1'b0;
      end else if (w_make | w_break) begin
         if (!w_ext && r_byte == SC_LSHIFT) r_lshift <= w_make;
         if (!w_ext && r_byte == SC_RSHIFT) r_rshift <= w_make;
         if (!w_ext && r_byte == SC_CTRL)   r_lctrl  <= w_make;
         if ( w_ext && r_byte == SC_CTRL)   r_rctrl  <= w_make;
         // caps_held blocks typematic repeats from toggling again
         if (!w_ext && r_byte == SC_CAPS) begin
            if (w_break) begin
               r_caps_held <= 1'b0;
            end else if (!r_caps_held) begin
               r_caps_lock <= ~r_caps_lock;
               r_caps_held <= 1'b1;
            end
         end
      end
   end

   assign caps_lock = r_caps_lock;

   logic [7:0]  w_code;
   logic [15:0] w_push_word;
   logic        w_push;

   ps2_keymap u_keymap (
      .i_scancode (r_byte),
      .i_ext      (w_ext),
      .i_shift    (w_shift),
      .i_caps     (r_caps_lock),
      .i_ctrl     (w_ctrl),
      .o_code     (w_code)
   );

   always_comb begin
      w_push_word                      = 16'h0000;
      w_push_word[KW_CODE_LSB +: 8]    = w_code;
      w_push_word[KW_EXT]              = w_ext;
      w_push_word[KW_SHIFT]            = w_shift;
      w_push_word[KW_CTRL]             = w_ctrl;
   end

   assign w_push = w_make && (w_code != 8'h00);

   logic [15:0] r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr, r_rd_ptr;
   logic        w_empty, w_full, w_pop, w_wr, w_drop, r_overflow;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = key_ack & ~w_empty;
   assign w_wr    = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr)       r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_drop)     r_overflow <= 1'b1;
         else if (w_pop) r_overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= w_push_word;
   end

   assign key_valid    = ~w_empty;
   assign key_data     = w_empty ? 16'h0000 : r_mem[r_rd_ptr[AW-1:0]];
   assign key_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ps2_scancode_decoder                                    |
// | Brief   : Directed, table-driven bench for ps2_scancode_decoder      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_ps2_scancode_decoder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  decoded_key = 8'h00;
   logic        read_key = 1'b0;
   logic        key_ack = 1'b0;
   logic        key_valid;
   logic [15:0] key_data;
   logic        key_overflow;
   logic        caps_lock;

   int n_tests = 0;
   int n_fail  = 0;

   ps2_scancode_decoder #(.FIFO_DEPTH(8)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .decoded_key  (decoded_key),
      .read_key     (read_key),
      .key_ack      (key_ack),
      .key_valid    (key_valid),
      .key_data     (key_data),
      .key_overflow (key_overflow),
      .caps_lock    (caps_lock)
   );

   always #10 clk = ~clk;

   typedef struct packed {
      logic [2:0]  nb;
      logic [39:0] bytes;
      logic        ev;
      logic [15:0] ed;
      logic        ec;
   } vec_t;

   localparam int NV = 27;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      decoded_key = b;
      read_key    = 1'b1;
      repeat (6) @(negedge clk);
      read_key    = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic pop();
      @(negedge clk);
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 10; k++) if (key_valid) pop();
   endtask

   // Push of b lands on the same edge as a pop
   task automatic send_byte_with_ack(input logic [7:0] b);
      @(negedge clk);
      decoded_key = b;
      read_key    = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
      repeat (4) @(negedge clk);
      read_key = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic do_reset();
      #3 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   logic [7:0] letters [9];

   initial begin
      vecs[0]  = '{3'd1, 40'h1C00000000, 1'b1, 16'h0061, 1'b0};
      vecs[1]  = '{3'd2, 40'hF01C000000, 1'b0, 16'h0000, 1'b0};
      vecs[2]  = '{3'd2, 40'h121C000000, 1'b1, 16'h0241, 1'b0};
      vecs[3]  = '{3'd3, 40'hF0121C0000, 1'b1, 16'h0061, 1'b0};
      vecs[4]  = '{3'd2, 40'h5916000000, 1'b1, 16'h0221, 1'b0};
      vecs[5]  = '{3'd3, 40'hF059160000, 1'b1, 16'h0031, 1'b0};
      vecs[6]  = '{3'd2, 40'hE075000000, 1'b1, 16'h0180, 1'b0};
      vecs[7]  = '{3'd3, 40'hE0F0750000, 1'b0, 16'h0000, 1'b0};
      vecs[8]  = '{3'd2, 40'hE072000000, 1'b1, 16'h0181, 1'b0};
      vecs[9]  = '{3'd2, 40'hE06B000000, 1'b1, 16'h0182, 1'b0};
      vecs[10] = '{3'd2, 40'hE074000000, 1'b1, 16'h0183, 1'b0};
      vecs[11] = '{3'd3, 40'hE0E0750000, 1'b1, 16'h0180, 1'b0};
      vecs[12] = '{3'd2, 40'h141C000000, 1'b1, 16'h0401, 1'b0};
      vecs[13] = '{3'd3, 40'hF0145A0000, 1'b1, 16'h000D, 1'b0};
      vecs[14] = '{3'd3, 40'hE0141C0000, 1'b1, 16'h0401, 1'b0};
      vecs[15] = '{3'd4, 40'hE0F0141C00, 1'b1, 16'h0061, 1'b0};
      vecs[16] = '{3'd1, 40'h2900000000, 1'b1, 16'h0020, 1'b0};
      vecs[17] = '{3'd1, 40'h7600000000, 1'b1, 16'h001B, 1'b0};
      vecs[18] = '{3'd1, 40'h6600000000, 1'b1, 16'h0008, 1'b0};
      vecs[19] = '{3'd1, 40'h0D00000000, 1'b1, 16'h0009, 1'b0};
      vecs[20] = '{3'd1, 40'h0700000000, 1'b0, 16'h0000, 1'b0};
      vecs[21] = '{3'd3, 40'h12141C0000, 1'b1, 16'h0601, 1'b0};
      vecs[22] = '{3'd4, 40'hF012F01400, 1'b0, 16'h0000, 1'b0};
      vecs[23] = '{3'd5, 40'h5858F0581C, 1'b1, 16'h0041, 1'b1};
      vecs[24] = '{3'd2, 40'h121C000000, 1'b1, 16'h0261, 1'b1};
      vecs[25] = '{3'd5, 40'hF01258F058, 1'b0, 16'h0000, 1'b0};
      vecs[26] = '{3'd2, 40'hE05A000000, 1'b0, 16'h0000, 1'b0};
      letters  = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("reset valid", key_valid, 0);
      chk("reset data", key_data, 0);
      chk("reset overflow", key_overflow, 0);
      chk("reset caps", caps_lock, 0);

      // key_valid must rise exactly on the third edge after read_key is first sampled
      @(negedge clk);
      decoded_key = 8'h1C;
      read_key    = 1'b1;
      for (int e = 0; e < 4; e++) begin
         @(posedge clk);
         #1;
         chk($sformatf("latency edge %0d", e), key_valid, (e == 3));
      end
      repeat (4) @(negedge clk);
      read_key = 1'b0;
      repeat (6) @(negedge clk);
      send_byte(8'hF0);
      send_byte(8'h1C);
      chk("first entry", key_data, 16'h0061);
      pop();
      chk("break pushes nothing", key_valid, 0);

      for (int i = 0; i < NV; i++) begin
         for (int j = 0; j < int'(vecs[i].nb); j++)
            send_byte(vecs[i].bytes[39 - 8*j -: 8]);
         chk($sformatf("vec%0d valid", i), key_valid, vecs[i].ev);
         if (vecs[i].ev) chk($sformatf("vec%0d data", i), key_data, vecs[i].ed);
         chk($sformatf("vec%0d caps", i), caps_lock, vecs[i].ec);
         if (key_valid) pop();
         chk($sformatf("vec%0d empty after pop", i), key_valid, 0);
         drain();
      end

      for (int k = 0; k < 9; k++) send_byte(letters[k]);
      chk("ovf head", key_data, 16'h0061);
      chk("ovf flag", key_overflow, 1);
      pop();
      chk("ovf cleared by pop", key_overflow, 0);
      for (int k = 1; k < 8; k++) begin
         chk($sformatf("ovf entry %0d", k), key_data, 16'h0061 + k);
         pop();
      end
      chk("ovf drained", key_valid, 0);
      pop();
      chk("ack empty valid", key_valid, 0);
      chk("ack empty data", key_data, 0);
      chk("ack empty overflow", key_overflow, 0);

      for (int k = 0; k < 8; k++) send_byte(letters[k]);
      chk("full valid", key_valid, 1);
      send_byte_with_ack(letters[8]);
      chk("full push+pop overflow", key_overflow, 0);
      for (int k = 1; k < 9; k++) begin
         chk($sformatf("full entry %0d", k), key_data, 16'h0061 + k);
         pop();
      end
      chk("full drained", key_valid, 0);

      send_byte(8'h58);
      send_byte(8'hF0);
      send_byte(8'h58);
      chk("caps before reset", caps_lock, 1);
      send_byte(8'h1C);
      send_byte(8'h12);
      send_byte(8'hE0);
      do_reset();
      chk("midreset valid", key_valid, 0);
      chk("midreset data", key_data, 0);
      chk("midreset caps", caps_lock, 0);
      send_byte(8'h1C);
      chk("after reset entry", key_data, 16'h0061);
      chk("after reset valid", key_valid, 1);
      drain();

      @(negedge clk);
      reset_n     = 1'b0;
      decoded_key = 8'h1C;
      read_key    = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("held read_key no push", key_valid, 0);
      read_key = 1'b0;
      repeat (6) @(negedge clk);
      chk("held read_key released", key_valid, 0);
      send_byte(8'h32);
      chk("alive after held", key_data, 16'h0062);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
